// File: rtl/psmac_stream.sv
// Precision-scalable streaming multiply-accumulate: one signed dot product per
// in_last-terminated vector, two register stages (multiply, accumulate).
module psmac_stream #(
  parameter int W     = 8,
  parameter int ACC_W = 20,
  parameter int SAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [W-1:0]            x,
  input  logic [W-1:0]            y,
  input  logic                    sx,
  input  logic                    sy,
  input  logic [1:0]              prec_x,
  input  logic [1:0]              prec_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_ovf,
  output logic                    out_err
);
  localparam int PW = 2 * W + 2;

  function automatic logic [W-1:0] prec_gate(input logic [W-1:0] v, input logic [1:0] p);
    logic [W-1:0] m;
    case (p)
      2'd0:    m = {{(W/4){1'b1}}, {(W-W/4){1'b0}}};
      2'd1:    m = {{(W/2){1'b1}}, {(W-W/2){1'b0}}};
      default: m = '1;
    endcase
    return v & m;
  endfunction

  function automatic logic signed [W:0] sgn_ext(input logic [W-1:0] v, input logic s);
    return $signed({s & v[W-1], v});
  endfunction

  // Returns {overflow, result}; the result is clamped when SAT is set.
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    logic                    ov;
    s  = a + b;
    ov = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    if (ov && SAT != 0)
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return {ov, s};
  endfunction

  logic                    adv;
  logic [5:0]              cfg_p0;
  logic signed [W:0]       xe_p0, ye_p0;
  logic signed [PW-1:0]    prod_p0;

  logic                    vld_p1, last_p1, err_p1;
  logic signed [PW-1:0]    prod_p1;
  logic [5:0]              cfg_q;
  logic                    in_first;

  logic signed [ACC_W-1:0] acc_p2;
  logic                    first_p2, ovf_p2, err_p2;
  logic signed [ACC_W-1:0] base_p1;
  logic [ACC_W:0]          add_p1;
  logic                    ov_p1;
  logic signed [ACC_W-1:0] nxt_p1;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign cfg_p0  = {prec_x, prec_y, sx, sy};
  assign xe_p0   = sgn_ext(prec_gate(x, prec_x), sx);
  assign ye_p0   = sgn_ext(prec_gate(y, prec_y), sy);
  assign prod_p0 = PW'(xe_p0) * PW'(ye_p0);

  // Stage 0 -> 1: gated multiply and per-beat config consistency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      in_first <= 1'b1;
    end else if (adv) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        prod_p1  <= prod_p0;
        last_p1  <= in_last;
        err_p1   <= !in_first && (cfg_p0 != cfg_q);
        if (in_first)
          cfg_q <= cfg_p0;
        in_first <= in_last;
      end
    end
  end

  assign base_p1 = first_p2 ? '0 : acc_p2;
  assign add_p1  = acc_add(base_p1, ACC_W'(prod_p1));
  assign ov_p1   = add_p1[ACC_W];
  assign nxt_p1  = $signed(add_p1[ACC_W-1:0]);

  // Stage 1 -> 2: accumulate, sticky flags, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2    <= '0;
      first_p2  <= 1'b1;
      ovf_p2    <= 1'b0;
      err_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (adv) begin
      if (vld_p1 && last_p1) begin
        out_sum   <= nxt_p1;
        out_ovf   <= ovf_p2 | ov_p1;
        out_err   <= err_p2 | err_p1;
        out_valid <= 1'b1;
        acc_p2    <= '0;
        first_p2  <= 1'b1;
        ovf_p2    <= 1'b0;
        err_p2    <= 1'b0;
      end else begin
        if (vld_p1) begin
          acc_p2   <= nxt_p1;
          first_p2 <= 1'b0;
          ovf_p2   <= ovf_p2 | ov_p1;
          err_p2   <= err_p2 | err_p1;
        end
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_psmac_stream.sv
// Bench for psmac_stream: three instances (wrap/20b, sat/18b, wrap/18b) share one
// stream and are scored against an arithmetic dot-product model.
module tb_psmac_stream;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_last, sx, sy, out_ready;
  logic [W-1:0] x, y;
  logic [1:0] prec_x, prec_y;
  logic rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic signed [19:0] sum0;
  logic signed [17:0] sum1, sum2;
  logic of0, of1, of2, er0, er1, er2;

  psmac_stream #(.W(W), .ACC_W(20), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
    .x(x), .y(y), .sx(sx), .sy(sy), .prec_x(prec_x), .prec_y(prec_y),
    .out_valid(vld0), .out_ready(out_ready), .out_sum(sum0), .out_ovf(of0), .out_err(er0));
  psmac_stream #(.W(W), .ACC_W(18), .SAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_last(in_last),
    .x(x), .y(y), .sx(sx), .sy(sy), .prec_x(prec_x), .prec_y(prec_y),
    .out_valid(vld1), .out_ready(out_ready), .out_sum(sum1), .out_ovf(of1), .out_err(er1));
  psmac_stream #(.W(W), .ACC_W(18), .SAT(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_last(in_last),
    .x(x), .y(y), .sx(sx), .sy(sy), .prec_x(prec_x), .prec_y(prec_y),
    .out_valid(vld2), .out_ready(out_ready), .out_sum(sum2), .out_ovf(of2), .out_err(er2));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct { longint s; bit o; bit e; } res_t;
  res_t q0[$], q1[$], q2[$];
  longint macc[3];
  bit     movf[3];
  bit     merr, mfirst;
  logic [5:0] mcfg;
  bit     held;
  longint prev_sum;
  bit     rand_ordy, bdone;

  function automatic longint opval(input logic [W-1:0] v, input logic [1:0] p, input logic s);
    int keep;
    longint g;
    keep = (p == 2'd0) ? W / 4 : (p == 2'd1) ? W / 2 : W;
    g = (longint'(v) >> (W - keep)) << (W - keep);
    if (s && g >= (longint'(1) << (W - 1))) g -= longint'(1) << W;
    return g;
  endfunction

  function automatic void step(input int k, input longint p, input int aw, input bit sat);
    longint mx, mn, s;
    mx = (longint'(1) << (aw - 1)) - 1;
    mn = -mx - 1;
    s  = macc[k] + p;
    if (s > mx || s < mn) begin
      movf[k] = 1'b1;
      if (sat) s = (s > mx) ? mx : mn;
      else begin
        s = s & ((longint'(1) << aw) - 1);
        if (s > mx) s -= longint'(1) << aw;
      end
    end
    macc[k] = s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      movf[k] = 1'b0;
    end
    merr   = 1'b0;
    mfirst = 1'b1;
  endfunction

  // Monitor/scoreboard: inputs and outputs are stable at the falling edge.
  initial begin
    res_t r;
    longint p;
    model_clear();
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete(); q1.delete(); q2.delete();
        model_clear();
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_sum", longint'(sum0), prev_sum);
          chk("hold_vld", longint'(vld0), 1);
        end
        if (vld0 && !out_ready) chk("stall_ready", longint'(rdy0), 0);
        if (vld0 && out_ready) begin
          if (q0.size() == 0) chk("res0_unexpected", longint'(q0.size()), 1);
          else begin
            r = q0.pop_front();
            chk("sum0", longint'(sum0), r.s); chk("ovf0", longint'(of0), longint'(r.o));
            chk("err0", longint'(er0), longint'(r.e));
          end
          if (q1.size() == 0) chk("res1_unexpected", longint'(q1.size()), 1);
          else begin
            r = q1.pop_front();
            chk("sum1", longint'(sum1), r.s); chk("ovf1", longint'(of1), longint'(r.o));
            chk("err1", longint'(er1), longint'(r.e));
          end
          if (q2.size() == 0) chk("res2_unexpected", longint'(q2.size()), 1);
          else begin
            r = q2.pop_front();
            chk("sum2", longint'(sum2), r.s); chk("ovf2", longint'(of2), longint'(r.o));
            chk("err2", longint'(er2), longint'(r.e));
          end
        end
        if (in_valid && rdy0) begin
          p = opval(x, prec_x, sx) * opval(y, prec_y, sy);
          if (mfirst) mcfg = {prec_x, prec_y, sx, sy};
          else if ({prec_x, prec_y, sx, sy} != mcfg) merr = 1'b1;
          step(0, p, 20, 1'b0);
          step(1, p, 18, 1'b1);
          step(2, p, 18, 1'b0);
          if (in_last) begin
            q0.push_back('{macc[0], movf[0], merr});
            q1.push_back('{macc[1], movf[1], merr});
            q2.push_back('{macc[2], movf[2], merr});
            model_clear();
          end else mfirst = 1'b0;
        end
        held     = vld0 && !out_ready;
        prev_sum = longint'(sum0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [W-1:0] vx, input logic [W-1:0] vy, input logic [1:0] px,
                      input logic [1:0] py, input logic vsx, input logic vsy, input logic vl);
    bit ok;
    ok = 1'b0;
    x = vx; y = vy; prec_x = px; prec_y = py; sx = vsx; sy = vsy; in_last = vl;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy0 && !rst) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", longint'(ok), 1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int len;
    logic [1:0] cpx, cpy, bpx, bpy;
    logic csx, csy, bsx, bsy;
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; x = 8'h55; y = 8'h33;
    sx = 1'b0; sy = 1'b0; prec_x = 2'd2; prec_y = 2'd2; out_ready = 1'b1;
    rand_ordy = 1'b0; bdone = 1'b0;
    repeat (3) tick();
    chk("rst_vld", longint'(vld0), 0);
    chk("rst_sum", longint'(sum0), 0);
    chk("rst_ovf", longint'(of0), 0);
    chk("rst_err", longint'(er0), 0);
    chk("rst_ready", longint'(rdy0), 1);
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) tick();
    chk("rst_ignored_beat", longint'(vld0), 0);

    // Full precision with latency
    send(8'h80, 8'h80, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
    send(8'h7F, 8'h7F, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1);
    chk("lat_early", longint'(vld0), 0);
    tick();
    chk("lat_vld", longint'(vld0), 1);
    chk("fp_sum", longint'(sum0), 32513);
    chk("fp_ovf", longint'(of0), 0);
    chk("fp_err", longint'(er0), 0);
    repeat (2) tick();

    // Mixed precision
    send(8'h7F, 8'h7F, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("mix_signed", longint'(sum0), 7168);
    send(8'hFF, 8'hFF, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("mix_unsigned", longint'(sum0), 46080);
    repeat (2) tick();

    // Saturation / wrap at 18 bits
    for (int i = 0; i < 3; i++) send(8'h80, 8'h80, 2'd2, 2'd2, 1'b1, 1'b1, 1'(i == 2));
    tick();
    chk("sat3_sum", longint'(sum1), 49152);
    chk("sat3_ovf", longint'(of1), 0);
    for (int i = 0; i < 9; i++) send(8'h80, 8'h80, 2'd2, 2'd2, 1'b1, 1'b1, 1'(i == 8));
    tick();
    chk("sat9_sum", longint'(sum1), 131071);
    chk("sat9_ovf", longint'(of1), 1);
    chk("wrap9_sum", longint'(sum2), -114688);
    chk("wrap9_ovf", longint'(of2), 1);
    repeat (2) tick();

    // Precision change mid-vector
    send(8'd2, 8'd3, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
    send(8'h10, 8'h10, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("pchg_sum", longint'(sum0), 262);
    chk("pchg_err", longint'(er0), 1);
    send(8'd1, 8'd1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1);
    tick();
    chk("pchg_next_err", longint'(er0), 0);
    repeat (2) tick();

    // Backpressure while the next vector streams
    out_ready = 1'b0;
    send(8'd3, 8'd4, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
    send(8'd5, 8'd6, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1);
    fork
      begin
        send(8'd1, 8'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
        send(8'd3, 8'd3, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
        send(8'd2, 8'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1);
        bdone = 1'b1;
      end
    join_none
    tick();
    chk("bp_first_sum", longint'(sum0), 42);
    repeat (3) tick();
    chk("bp_ready_low", longint'(rdy0), 0);
    chk("bp_sum_held", longint'(sum0), 42);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !bdone; i++) @(posedge clk);
    if (!bdone) chk("bp_done", longint'(bdone), 1);
    #1;
    tick();
    chk("bp_next_sum", longint'(sum0), 15);
    repeat (2) tick();

    // Reset mid-vector
    send(8'd9, 8'd9, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
    send(8'd8, 8'd8, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk("rstmid_vld", longint'(vld0), 0);
    rst = 1'b0;
    send(8'd5, 8'd7, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rstmid_vld_after", longint'(vld0), 1);
    chk("rstmid_sum", longint'(sum0), 35);
    repeat (2) tick();

    // Randomized vectors with bubbles and random backpressure
    rand_ordy = 1'b1;
    for (int v = 0; v < 150; v++) begin
      len = $urandom_range(1, 6);
      cpx = 2'($urandom_range(0, 3)); cpy = 2'($urandom_range(0, 3));
      csx = 1'($urandom_range(0, 1)); csy = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        bpx = cpx; bpy = cpy; bsx = csx; bsy = csy;
        if ($urandom_range(0, 9) == 0) bpx = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) bsy = ~bsy;
        repeat ($urandom_range(0, 2)) tick();
        send(8'($urandom), 8'($urandom), bpx, bpy, bsx, bsy, 1'(b == len - 1));
      end
    end
    rand_ordy = 1'b0;
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (q0.size() + q1.size() + q2.size()) != 0; i++) tick();
    chk("drain0", longint'(q0.size()), 0);
    chk("drain1", longint'(q1.size()), 0);
    chk("drain2", longint'(q2.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/psmac_stream.md
# psmac_stream

Parametrised, pipelined, precision-scalable multiply-accumulate engine with a valid/ready streaming interface. It computes dot products of length ≥1 over a stream of operand pairs, with independent per-operand precision (W/4, W/2 or W bits, MSB-aligned) and per-operand signedness. It adds optional saturation and overflow/consistency flags, and emits one result per vector marked by `in_last`. It sits between the operand fetch stream and the output writeback in the accelerator datapath.

## Interface
- `W`, 8: operand width; must be a multiple of 4, ≥ 4.
- `ACC_W`, 20: accumulator/result width; must be ≥ 2W+2.
- `SAT`, 0: 1 = clamp the accumulator to the signed ACC_W range on overflow; 0 = two's-complement wrap.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  engine can accept a beat this cycle.
- `in_last`  in  1  beat is the final element of the current vector.
- `x`, `y`  in  W  operands, MSB-aligned.
- `sx`, `sy`  in  1  1 = operand is signed two's complement; 0 = unsigned.
- `prec_x`, `prec_y`  in  2  0 keeps the top W/4 bits; 1 keeps the top W/2; 2 and 3 keep all W bits. Lower bits are forced to 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_W  dot-product result (signed).
- `out_ovf`  out  1  accumulation overflowed at least once in this vector.
- `out_err`  out  1  `prec_x`/`prec_y`/`sx`/`sy` changed within this vector.

## Operation
- **Handshake.** A beat is accepted when `in_valid && in_ready` at a rising edge. Define `adv = !out_valid || out_ready`, and drive `in_ready = adv` (combinational). When `adv` is 0, the whole pipeline stalls and all state holds.
- **Stage 1 (on accept).**
  - Gate `x` and `y` per `prec_*`.
  - Extend each gated operand to W+1 bits: sign extension if `s*`=1, zero extension otherwise.
  - Multiply to a 2W+2-bit signed product and register it with valid, last and err bits.
  - `err` is set when the beat is not the first of a vector and its `{prec_x, prec_y, sx, sy}` differs from the value latched on the vector's first beat.
  - Every beat is gated by its own precision, regardless of `err`.
- **Stage 2 (when `adv` and stage-1 valid).**
  - Sign-extend the product to ACC_W. Compute `nxt = (first ? 0 : acc) + prod`, where `first` means the accumulator is empty.
  - Signed overflow sets a sticky ovf bit. If `SAT`=1, `nxt` clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Without last: `acc <= nxt`.
  - With last:
    - `out_sum <= nxt`.
    - `out_ovf` and `out_err` take the sticky bits ORed with this beat's bits.
    - `out_valid <= 1`.
    - The accumulator and the sticky bits clear, and the next beat starts a new vector.
- **Result drop.** If `out_valid && out_ready` and no new last completes in the same cycle, `out_valid <= 0`. If a new last does complete in that cycle, `out_valid` stays 1 and `out_sum` updates back-to-back.
- **Outputs.** `out_sum`, `out_ovf` and `out_err` are held stable while `out_valid && !out_ready`.
- **Reset.** `rst` clears `acc`, the sticky bits, stage-1 valid, `out_valid`, `out_sum`, `out_ovf`, `out_err` and the first-flag (set to 1). This includes reset mid-vector: any partial vector is discarded and no result is emitted. `rst` overrides every other input.
- **Idle cycles.** `in_valid`=0 mid-vector inserts a bubble, and the accumulator holds.

## Timing
- All outputs are 0 after reset. `in_ready` is 1 during and after reset, but beats presented while `rst`=1 are ignored.
- **Latency.** A last beat accepted at edge T gives `out_valid`=1 after edge T+1, when unstalled.
- **Throughput.** One beat per cycle while `out_ready`=1 or no result is pending. A 1-beat vector on every cycle yields one result per cycle.
- **Backpressure.** With `out_valid`=1 and `out_ready`=0, `in_ready`=0 in the same cycle and no stage advances. The in-flight stage-1 beat is never lost or duplicated.
- **Critical path.** The stage-1 multiply and the stage-2 add plus saturate are each one register stage. No combinational path exists from `x`/`y` to any output.

## Test plan
- **Full precision.** W=8, `prec`=2/2, `sx`=`sy`=1, beats (-128,-128), (127,127 with last) -> `out_sum`=32513, `out_ovf`=0, `out_err`=0. `out_valid` is high after the edge following the last-beat accept.
- **Mixed precision.** `prec_x`=0, `prec_y`=1, signed, single beat x=0x7F, y=0x7F, last -> gated values 64 and 112, `out_sum`=7168. Repeat with `sx`=`sy`=0, x=0xFF, y=0xFF -> 192·240 = 46080.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles while a result is pending and the next vector is streaming -> `in_ready`=0 for those cycles and `out_sum` stays stable. After release, the next vector's sum is exact, with no lost or duplicated beat.
- **Saturation.** ACC_W=18, `SAT`=1, 3 signed beats (-128,-128) -> the raw sum of 49152 fits, so no clamp and `out_ovf`=0. Then 9 beats -> 147456 exceeds 131071, giving `out_sum`=131071 and `out_ovf`=1. With `SAT`=0, the same 9 beats give the wrapped value -114688 and `out_ovf`=1.
- **Precision change mid-vector.** Beats (8b, x=2, y=3), then (4b/4b, x=0x10, y=0x10, last) -> `out_sum`=6+256=262 and `out_err`=1. The next vector has `out_err`=0.
- **Reset mid-vector.** Accept 2 beats, assert `rst` for 1 cycle, then send a single beat (5,7) with last -> `out_sum`=35. No result appears for the aborted vector, and `out_valid`=0 during reset.
